// File: rtl/bp_pkg.sv
// Shared constants and types for the branch target buffer.
// The 2-bit direction counter encoding is common to the table and the counter sub-module.
package bp_pkg;

  localparam int unsigned BP_CNT_W  = 2;
  localparam int unsigned BP_ADDR_W = 32;

  localparam logic [BP_CNT_W-1:0] BP_SNT = 2'b00;
  localparam logic [BP_CNT_W-1:0] BP_WNT = 2'b01;
  localparam logic [BP_CNT_W-1:0] BP_WT  = 2'b10;
  localparam logic [BP_CNT_W-1:0] BP_ST  = 2'b11;

  // Default-width table entry; the top re-declares it at its own ADDR_W.
  typedef struct packed {
    logic                 valid;
    logic [BP_ADDR_W-1:0] tag;
    logic [BP_ADDR_W-1:0] target;
    logic [BP_CNT_W-1:0]  cnt;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [BP_CNT_W-1:0] cnt,
  input  logic                taken,
  output logic [BP_CNT_W-1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != BP_ST) cnt_next = cnt + BP_CNT_W'(1);
    end else begin
      if (cnt != BP_SNT) cnt_next = cnt - BP_CNT_W'(1);
    end
  end

endmodule

// File: rtl/bp_btb.sv
// Fully associative branch target buffer with round-robin allocation and
// per-entry 2-bit direction counters; prediction is combinational from f_pc.
module bp_btb
  import bp_pkg::*;
#(
  parameter int unsigned          ENTRIES  = 4,
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [BP_CNT_W-1:0]  CNT_INIT = BP_WNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] f_predict_addr,
  output logic              f_predict_valid,
  input  logic              d_is_branch,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [ADDR_W-1:0] d_target,
  input  logic              x_valid,
  input  logic [ADDR_W-1:0] x_pc,
  input  logic              x_taken,
  input  logic [ADDR_W-1:0] x_target
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic                valid;
    logic [ADDR_W-1:0]   tag;
    logic [ADDR_W-1:0]   target;
    logic [BP_CNT_W-1:0] cnt;
  } entry_t;

  entry_t              tbl_q [ENTRIES];
  entry_t              tbl_d [ENTRIES];
  logic [IDX_W-1:0]    rr_q;
  logic [IDX_W-1:0]    rr_d;

  logic [ENTRIES-1:0]  f_hit;
  logic [ENTRIES-1:0]  d_hit;
  logic [ENTRIES-1:0]  x_hit;
  logic [IDX_W-1:0]    f_idx;
  logic [IDX_W-1:0]    x_idx;
  logic                alloc;
  logic                train;
  logic [BP_CNT_W-1:0] x_cnt_next;

  // Three parallel tag comparator banks, all against pre-edge state.
  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      f_hit[i] = tbl_q[i].valid && (tbl_q[i].tag == f_pc);
      d_hit[i] = tbl_q[i].valid && (tbl_q[i].tag == d_pc);
      x_hit[i] = tbl_q[i].valid && (tbl_q[i].tag == x_pc);
    end
  end

  // Lowest matching index wins; the descending scan leaves it last.
  always_comb begin
    f_idx = '0;
    x_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (f_hit[i]) f_idx = IDX_W'(i);
      if (x_hit[i]) x_idx = IDX_W'(i);
    end
  end

  always_comb begin
    f_predict_valid = 1'b0;
    f_predict_addr  = '0;
    if ((|f_hit) && tbl_q[f_idx].cnt[1]) begin
      f_predict_valid = 1'b1;
      f_predict_addr  = tbl_q[f_idx].target;
    end
  end

  assign alloc = d_is_branch && !(|d_hit);
  assign train = x_valid && (|x_hit);

  bp_sat_counter u_sat_counter (
    .cnt      (tbl_q[x_idx].cnt),
    .taken    (x_taken),
    .cnt_next (x_cnt_next)
  );

  // Train first, then allocate, so an allocation onto the trained entry wins.
  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      tbl_d[i] = tbl_q[i];
    end
    rr_d = rr_q;
    if (train) begin
      tbl_d[x_idx].cnt = x_cnt_next;
      if (x_taken) tbl_d[x_idx].target = x_target;
    end
    if (alloc) begin
      tbl_d[rr_q].valid  = 1'b1;
      tbl_d[rr_q].tag    = d_pc;
      tbl_d[rr_q].target = d_target;
      tbl_d[rr_q].cnt    = CNT_INIT;
      rr_d               = rr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid <= 1'b0;
      end
      rr_q <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
      rr_q <= rr_d;
    end
  end

endmodule
